// File: rtl/seven_segment_pkg.sv
// ============================================================================
// seven_segment_pkg : register map, CTRL reset value and segment LUT
// Revision 1.0
// ============================================================================
`default_nettype none

package seven_segment_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  localparam int         c_ctrl_w     = 17;
  localparam logic [16:0] c_ctrl_reset = 17'h1_00FF;

  // gfedcba, active-high, indexed by hex value
  localparam logic [6:0] c_seg_lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lane_sel);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (lane_sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_wb_ctrl_if.sv
// ============================================================================
// seven_segment_wb_ctrl_if : Wishbone B4 classic bus carrying clk / rst
// Revision 1.0
// ============================================================================
`default_nettype none

interface seven_segment_wb_ctrl_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;

  modport master (
    input  clk, rst, dat_o, ack,
    output cyc, stb, we, adr, sel, dat_i
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_i,
    output dat_o, ack
  );
endinterface

`default_nettype wire

// File: rtl/seven_segment_wb_ctrl_hex_to_seg.sv
// ============================================================================
// hex_to_seg : 4-bit nibble to active-high gfedcba segment pattern
// Revision 1.0
// ============================================================================
`default_nettype none

module hex_to_seg
  import seven_segment_pkg::*;
(
  input  wire logic [3:0] nibble_i,
  output logic      [6:0] seg_o
);
  assign seg_o = c_seg_lut[nibble_i];
endmodule

`default_nettype wire

// File: rtl/seven_segment_wb_ctrl.sv
// ============================================================================
// seven_segment_wb_ctrl : Wishbone slave scanning an 8-digit 7-seg display
// Revision 1.0
// ============================================================================
`default_nettype none

module seven_segment_wb_ctrl
  import seven_segment_pkg::*;
#(
  parameter int REFRESH_DIV = 16,
  parameter int NUM_DIGITS  = 8
) (
  seven_segment_wb_ctrl_if.slave wb,
  output logic [7:0] display_data,
  output logic [7:0] select
);
  localparam int PW    = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [31:0]         data_q,  data_d;
  logic [c_ctrl_w-1:0] ctrl_q,  ctrl_d;
  logic [31:0]         dat_o_q, dat_o_d;
  logic                ack_q,   ack_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [7:0]          sel_q,   sel_d;
  logic [7:0]          disp_q,  disp_d;

  logic       w_req;
  reg_sel_e   w_reg;
  logic       w_wrap;
  logic       w_lit;
  logic [3:0] w_nibble;
  logic [6:0] w_seg;
  logic       w_adr_unused;

  assign w_adr_unused = ^{wb.adr[31:4], wb.adr[1:0]};

  assign w_req    = wb.cyc & wb.stb & ~ack_q;
  assign w_reg    = reg_sel_e'(wb.adr[3:2]);
  assign w_wrap   = (presc_q == PW'(REFRESH_DIV - 1));
  assign w_lit    = ctrl_q[16] & ctrl_q[idx_q];
  assign w_nibble = data_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble_i (w_nibble),
    .seg_o    (w_seg)
  );

  always_comb begin
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    dat_o_d = dat_o_q;
    ack_d   = w_req;
    if (w_req) begin
      if (wb.we) begin
        // STATUS and the reserved slot swallow writes but still ack
        case (w_reg)
          REG_DATA: data_d = merge_lanes(data_q, wb.dat_i, wb.sel);
          REG_CTRL: ctrl_d = c_ctrl_w'(merge_lanes(32'(ctrl_q), wb.dat_i, wb.sel));
          default:  ;
        endcase
      end else begin
        case (w_reg)
          REG_DATA:   dat_o_d = data_q;
          REG_CTRL:   dat_o_d = 32'(ctrl_q);
          REG_STATUS: dat_o_d = 32'(idx_q);
          default:    dat_o_d = 32'h0;
        endcase
      end
    end
  end

  always_comb begin
    presc_d = w_wrap ? '0 : presc_q + PW'(1);
    idx_d   = w_wrap ? idx_q + IDX_W'(1) : idx_q;
    sel_d   = w_lit ? ~(8'h01 << idx_q) : 8'hFF;
    disp_d  = w_lit ? ~{ctrl_q[8 + idx_q], w_seg} : 8'hFF;
  end

  always_ff @(posedge wb.clk or negedge wb.rst) begin
    if (!wb.rst) begin
      data_q  <= '0;
      ctrl_q  <= c_ctrl_reset;
      dat_o_q <= '0;
      ack_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      sel_q   <= 8'hFF;
      disp_q  <= 8'hFF;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      dat_o_q <= dat_o_d;
      ack_q   <= ack_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      disp_q  <= disp_d;
    end
  end

  assign wb.dat_o     = dat_o_q;
  assign wb.ack       = ack_q;
  assign select       = sel_q;
  assign display_data = disp_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_wb_ctrl.sv
// ============================================================================
// tb_seven_segment_wb_ctrl : self-checking bench for seven_segment_wb_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_seven_segment_wb_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] display_data;
  logic [7:0] select;

  seven_segment_wb_ctrl_if wb (.clk(clk), .rst(rst_n));

  seven_segment_wb_ctrl #(.REFRESH_DIV(4), .NUM_DIGITS(8)) dut (
    .wb           (wb),
    .display_data (display_data),
    .select       (select)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  adr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } reg_vec_t;

  reg_vec_t    vecs [7];
  logic [31:0] exp_q [$];
  logic [31:0] m_data;
  logic [31:0] m_ctrl;
  logic [6:0]  seg_tb [16];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [3:0] s, input logic [31:0] wd);
    if (a == 4'h0) m_data = lanes(m_data, wd, s);
    if (a == 4'h4) m_ctrl = lanes(m_ctrl, wd, s) & 32'h0001_FFFF;
  endtask

  // called at a negedge; returns at the negedge after the ack pulse ended
  task automatic wb_xfer(input logic we, input logic [3:0] a, input logic [3:0] s,
                         input logic [31:0] wd, output logic [31:0] rd);
    int n;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
    wb.adr = {28'h0, a}; wb.sel = s; wb.dat_i = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb.ack && n < 20);
    chk("ack_seen", {31'b0, wb.ack}, 32'd1);
    rd = wb.dat_o;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    @(negedge clk);
    chk("ack_pulse", {31'b0, wb.ack}, 32'd0);
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [3:0] s, input logic [31:0] wd);
    logic [31:0] rd;
    model_write(a, s, wd);
    wb_xfer(1'b1, a, s, wd, rd);
  endtask

  task automatic wb_read_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic [31:0] e;
    exp_q.push_back(exp);
    wb_xfer(1'b0, a, 4'hF, 32'h0, rd);
    e = exp_q.pop_front();
    chk(name, rd, e);
  endtask

  task automatic exp_digit(input int d, output logic [7:0] e_sel, output logic [7:0] e_disp);
    logic       lit;
    logic [7:0] one;
    one = 8'h01;
    lit = m_ctrl[16] & m_ctrl[d];
    e_sel  = lit ? ~(one << d) : 8'hFF;
    e_disp = lit ? ~{m_ctrl[8 + d], seg_tb[m_data[4*d +: 4]]} : 8'hFF;
  endtask

  // anchor must be a lit digit; samples once per digit slot for a full scan
  task automatic scan_walk(input int anchor);
    int         n;
    int         d;
    logic [7:0] a_sel;
    logic [7:0] e_sel;
    logic [7:0] e_disp;
    logic [7:0] one;
    one   = 8'h01;
    a_sel = ~(one << anchor);
    n = 0;
    while (select !== a_sel && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("scan_align", {24'h0, select}, {24'h0, a_sel});
    for (int k = 0; k < 8; k++) begin
      d = (anchor + k) % 8;
      exp_digit(d, e_sel, e_disp);
      chk($sformatf("scan_sel_d%0d", d),  {24'h0, select},       {24'h0, e_sel});
      chk($sformatf("scan_disp_d%0d", d), {24'h0, display_data}, {24'h0, e_disp});
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] s0;

    seg_tb = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{4'h0, 4'b0001, 32'hFFFF_FFFF, 32'h8765_43FF};
    vecs[1] = '{4'h4, 4'b1111, 32'hFFFF_FFFF, 32'h0001_FFFF};
    vecs[2] = '{4'h4, 4'b0100, 32'h0000_0000, 32'h0000_FFFF};
    vecs[3] = '{4'h4, 4'b1111, 32'h0001_00FF, 32'h0001_00FF};
    vecs[4] = '{4'hC, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{4'h0, 4'b1010, 32'h1122_3344, 32'h1165_33FF};
    vecs[6] = '{4'h0, 4'b1010, 32'h8700_4300, 32'h8765_43FF};

    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.adr = 32'h0; wb.sel = 4'h0; wb.dat_i = 32'h0;
    m_data = 32'h0;
    m_ctrl = 32'h0001_00FF;

    repeat (10) @(negedge clk);
    chk("rst_select", {24'h0, select},       32'hFF);
    chk("rst_disp",   {24'h0, display_data}, 32'hFF);
    chk("rst_ack",    {31'b0, wb.ack},       32'h0);
    chk("rst_dat_o",  wb.dat_o,              32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read_chk("rst_data", 4'h0, 32'h0);
    wb_read_chk("rst_ctrl", 4'h4, 32'h0001_00FF);

    wb_write(4'h0, 4'hF, 32'h8765_4321);
    wb_read_chk("data_rd", 4'h0, 32'h8765_4321);
    scan_walk(0);

    for (int i = 0; i < 7; i++) begin
      wb_write(vecs[i].adr, vecs[i].sel, vecs[i].wdata);
      wb_read_chk($sformatf("vec%0d_rd", i), vecs[i].adr, vecs[i].exp_rd);
    end

    wb_write(4'h0, 4'b0001, 32'hFFFF_FFFF);
    wb_write(4'h8, 4'hF, 32'hFFFF_FFFF);
    wb_read_chk("data_after_status_wr", 4'h0, 32'h8765_43FF);
    scan_walk(0);

    wb_write(4'h4, 4'hF, 32'h0001_01FE);
    scan_walk(1);
    wb_write(4'h4, 4'hF, 32'h0001_01FF);
    scan_walk(0);

    // back-to-back request held high: ack alternates
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h0; wb.sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_ack", {31'b0, wb.ack}, {31'b0, (i % 2 == 0)});
      if (i == 0) chk("b2b_dat", wb.dat_o, m_data);
    end
    wb.cyc = 1'b0; wb.stb = 1'b0;
    @(negedge clk);

    // strobe without cycle is ignored
    wb.cyc = 1'b0; wb.stb = 1'b1; wb.we = 1'b1; wb.adr = 32'h0; wb.dat_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nocyc_ack", {31'b0, wb.ack}, 32'h0);
    end
    wb.stb = 1'b0; wb.we = 1'b0;
    @(negedge clk);
    wb_read_chk("nocyc_data", 4'h0, m_data);

    wb_write(4'h4, 4'hF, 32'h0000_00FF);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("gdis_select", {24'h0, select}, 32'hFF);
    end
    wb_xfer(1'b0, 4'h8, 4'hF, 32'h0, s0);
    for (int k = 1; k < 8; k++) begin
      repeat (2) @(negedge clk);
      wb_read_chk("status_idx", 4'h8, (s0 + k) % 8);
    end

    wb_write(4'h4, 4'hF, 32'h0001_00FF);
    wb_xfer(1'b0, 4'h0, 4'hF, 32'h0, rd);
    repeat (3) @(negedge clk);

    // reset asserted while a write is being acked
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1;
    wb.adr = 32'h0; wb.sel = 4'hF; wb.dat_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    chk("midrst_pre_ack", {31'b0, wb.ack}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack",    {31'b0, wb.ack},       32'h0);
    chk("midrst_select", {24'h0, select},       32'hFF);
    chk("midrst_disp",   {24'h0, display_data}, 32'hFF);
    chk("midrst_dat_o",  wb.dat_o,              32'h0);
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_data = 32'h0;
    m_ctrl = 32'h0001_00FF;
    @(negedge clk);
    wb_read_chk("postrst_data", 4'h0, 32'h0);
    wb_read_chk("postrst_ctrl", 4'h4, 32'h0001_00FF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
